// File: rtl/pll_sup_pkg.sv
// Shared types for the PLL lock supervisor.
// State encoding and lock-loss counter ceiling.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam logic [7:0] LOSS_CNT_MAX = 8'hFF;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser, async active-low reset.
// Ports: clk, rst_n, d (async in), q (synchronised out).
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer with stability filter, retries and fault.
// Ports: refclk, rst_n, pll_locked, restart -> pll_rst, sys_rst_n,
//   locked_stable, fault, retry_cnt, lock_loss_cnt.
module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES      = 50,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 16,
  parameter int RETRY_W             = 4
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               restart,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic               locked_stable,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [7:0]         lock_loss_cnt
);

  import pll_sup_pkg::*;

  localparam logic [CNT_W-1:0] RST_LAST =
    CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST =
    CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX =
    RETRY_W'(MAX_RETRIES);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [RETRY_W-1:0] retry_n;
  logic [7:0]         loss_n;
  logic               locked_s;

  sync_2ff u_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    retry_n = retry_cnt;
    loss_n  = lock_loss_cnt;
    if (restart) begin
      state_n = RESET_PLL;
      cnt_n   = '0;
      retry_n = '0;
    end else begin
      unique case (state)
        RESET_PLL: begin
          if (cnt == RST_LAST) begin
            state_n = WAIT_LOCK;
            cnt_n   = '0;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_n = STABILIZE;
            cnt_n   = '0;
          end else if (cnt == TO_LAST) begin
            cnt_n = '0;
            if (retry_cnt < RETRY_MAX) begin
              retry_n = retry_cnt + 1'b1;
              state_n = RESET_PLL;
            end else begin
              state_n = FAULT;
            end
          end
        end
        STABILIZE: begin
          if (!locked_s) begin
            state_n = WAIT_LOCK;
            cnt_n   = '0;
          end else if (cnt == STB_LAST) begin
            state_n = RUN;
            cnt_n   = '0;
          end
        end
        RUN: begin
          cnt_n   = '0;
          retry_n = '0;
          if (!locked_s) begin
            state_n = RESET_PLL;
            if (lock_loss_cnt != LOSS_CNT_MAX)
              loss_n = lock_loss_cnt + 8'd1;
          end
        end
        FAULT: begin
          cnt_n = '0;
        end
        default: begin
          state_n = RESET_PLL;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Outputs decode next state so they move on the same edge.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RESET_PLL;
      cnt           <= '0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
      pll_rst       <= 1'b1;
      sys_rst_n     <= 1'b0;
      locked_stable <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      retry_cnt     <= retry_n;
      lock_loss_cnt <= loss_n;
      pll_rst       <= (state_n == RESET_PLL) ||
                       (state_n == FAULT);
      sys_rst_n     <= (state_n == RUN);
      locked_stable <= (state_n == RUN);
      fault         <= (state_n == FAULT);
    end
  end

endmodule
